// File: rtl/downsample_pkg.sv
// Shared types and constants for the fractional-stride downsample controller.
package downsample_pkg;

   // Number of fractional bits in the Q8.8 stride and accumulators.
   localparam int unsigned FRAC_BITS = 8;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      CAPTURE,
      PRESENT,
      DONE
   } ds_state_t;

endpackage

// File: rtl/ds_coord_gen.sv
// Output-pixel scanner and source-index generator.
// Walks (oy, ox) row-major and keeps Q8.8 row/column accumulators that advance by
// the stride on each step, so src = floor(o * stride) comes out without multipliers.
module ds_coord_gen
   import downsample_pkg::*;
#(
   parameter int unsigned STRIDE_Q8_8 = 369,
   parameter int unsigned HIN         = 27,
   parameter int unsigned HOUT        = 19
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clear,
   input  logic                     step,
   output logic [$clog2(HOUT)-1:0]  ox,
   output logic [$clog2(HOUT)-1:0]  oy,
   output logic [$clog2(HIN)-1:0]   src_row,
   output logic [$clog2(HIN)-1:0]   src_col,
   output logic                     last
);

   localparam int unsigned XW   = $clog2(HOUT);
   localparam int unsigned SW   = $clog2(HIN);
   // Wide enough for (HOUT-1)*stride, the largest value either accumulator reaches.
   localparam int unsigned ACCW = $clog2((HOUT - 1) * STRIDE_Q8_8 + 1);

   logic [ACCW-1:0] row_acc;
   logic [ACCW-1:0] col_acc;
   logic [ACCW-1:0] row_int;
   logic [ACCW-1:0] col_int;
   logic            row_end;

   assign row_end = (ox == XW'(HOUT - 1));
   assign last    = row_end && (oy == XW'(HOUT - 1));

   // Advance the scan position and accumulators; the column restarts at zero each row.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ox      <= '0;
         oy      <= '0;
         row_acc <= '0;
         col_acc <= '0;
      end else if (clear) begin
         ox      <= '0;
         oy      <= '0;
         row_acc <= '0;
         col_acc <= '0;
      end else if (step) begin
         if (row_end) begin
            ox      <= '0;
            col_acc <= '0;
            oy      <= oy + XW'(1);
            row_acc <= row_acc + ACCW'(STRIDE_Q8_8);
         end else begin
            ox      <= ox + XW'(1);
            col_acc <= col_acc + ACCW'(STRIDE_Q8_8);
         end
      end
   end

   assign row_int = row_acc >> FRAC_BITS;
   assign col_int = col_acc >> FRAC_BITS;

   // Integer part of each accumulator, clamped to the last input row/column.
   always_comb begin
      src_row = SW'(row_int);
      src_col = SW'(col_int);
      if (row_int > ACCW'(HIN - 1)) begin
         src_row = SW'(HIN - 1);
      end
      if (col_int > ACCW'(HIN - 1)) begin
         src_col = SW'(HIN - 1);
      end
   end

endmodule

// File: rtl/downsample_ctrl.sv
// Fractional-stride downsample controller: for every output pixel, reads one
// source pixel from the ifmap SRAM and presents it on a valid/ready port.
module downsample_ctrl
   import downsample_pkg::*;
#(
   parameter int unsigned STRIDE_Q8_8 = 369,
   parameter int unsigned HIN         = 27,
   parameter int unsigned HOUT        = 19
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           start,
   input  logic                           abort,
   output logic                           busy,
   output logic                           done,
   output logic                           mem_rd_en,
   output logic [$clog2(HIN*HIN)-1:0]     mem_rd_addr,
   input  logic [7:0]                     mem_rd_data,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [7:0]                     out_data,
   output logic [$clog2(HOUT*HOUT)-1:0]   out_addr
);

   localparam int unsigned RAW = $clog2(HIN * HIN);
   localparam int unsigned OAW = $clog2(HOUT * HOUT);
   localparam int unsigned XW  = $clog2(HOUT);
   localparam int unsigned SW  = $clog2(HIN);

   ds_state_t       state;
   logic [XW-1:0]   ox;
   logic [XW-1:0]   oy;
   logic [SW-1:0]   src_row;
   logic [SW-1:0]   src_col;
   logic            last;
   logic            pix_last;
   logic            coord_clear;
   logic            coord_step;
   logic [RAW-1:0]  src_addr;
   logic [OAW-1:0]  dst_addr;

   // Coordinates return to the origin when a map ends or is cancelled. They step
   // right after the read is issued, so the next address is ready by the handshake.
   assign coord_clear = (state == DONE) || (abort && (state != IDLE));
   assign coord_step  = (state == ISSUE) && !abort && !last;

   ds_coord_gen #(
      .STRIDE_Q8_8 (STRIDE_Q8_8),
      .HIN         (HIN),
      .HOUT        (HOUT)
   ) u_coord (
      .clk     (clk),
      .rst     (rst),
      .clear   (coord_clear),
      .step    (coord_step),
      .ox      (ox),
      .oy      (oy),
      .src_row (src_row),
      .src_col (src_col),
      .last    (last)
   );

   // Constant-coefficient address products (HIN and HOUT are parameters).
   assign src_addr = RAW'(src_row) * RAW'(HIN) + RAW'(src_col);
   assign dst_addr = OAW'(oy) * OAW'(HOUT) + OAW'(ox);

   // Main control FSM with registered outputs; abort overrides everything but reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         busy        <= 1'b0;
         done        <= 1'b0;
         mem_rd_en   <= 1'b0;
         mem_rd_addr <= '0;
         out_valid   <= 1'b0;
         out_data    <= '0;
         out_addr    <= '0;
         pix_last    <= 1'b0;
      end else if (abort && (state != IDLE)) begin
         state     <= IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         mem_rd_en <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  state       <= ISSUE;
                  busy        <= 1'b1;
                  mem_rd_en   <= 1'b1;
                  mem_rd_addr <= src_addr;
                  out_addr    <= dst_addr;
               end
            end
            ISSUE: begin
               mem_rd_en <= 1'b0;
               pix_last  <= last;
               state     <= CAPTURE;
            end
            CAPTURE: begin
               out_data  <= mem_rd_data;
               out_valid <= 1'b1;
               state     <= PRESENT;
            end
            PRESENT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  if (pix_last) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     state       <= ISSUE;
                     mem_rd_en   <= 1'b1;
                     mem_rd_addr <= src_addr;
                     out_addr    <= dst_addr;
                  end
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_downsample_ctrl.sv
// Scoreboard bench for downsample_ctrl: the stimulus side queues expected pixels
// from an arithmetic reference model, and a monitor pops them on each handshake.
module tb_downsample_ctrl;

   localparam int S    = 369;
   localparam int HIN  = 27;
   localparam int HOUT = 19;
   localparam int NPIX = HOUT * HOUT;

   typedef struct {
      int addr;
      int src;
      int data;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       abort;
   logic       busy;
   logic       done;
   logic       mem_rd_en;
   logic [9:0] mem_rd_addr;
   logic [7:0] mem_rd_data;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic [8:0] out_addr;

   logic       c_start;
   logic       c_busy;
   logic       c_done;
   logic       c_mem_rd_en;
   logic [5:0] c_mem_rd_addr;
   logic [7:0] c_mem_rd_data;
   logic       c_out_valid;
   logic       c_out_ready;
   logic [7:0] c_out_data;
   logic [4:0] c_out_addr;

   logic [7:0] mem   [0:HIN*HIN-1];
   logic [7:0] c_mem [0:63];

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   hs_count = 0;
   int   done_count = 0;
   int   first_addr = -1;
   int   last_rd = 0;
   int   obs_src  [0:511];
   int   obs_data [0:511];
   int   ready_mode = 0;
   int   stall_armed = 0;
   int   stall_hits = 0;

   int   c_hs = 0;
   int   c_done_count = 0;
   int   c_last_rd = 0;
   int   c_src [0:31];
   int   c_dat [0:31];
   int   c_adr [0:31];

   always #5 clk = ~clk;

   downsample_ctrl #(
      .STRIDE_Q8_8 (S),
      .HIN         (HIN),
      .HOUT        (HOUT)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .abort       (abort),
      .busy        (busy),
      .done        (done),
      .mem_rd_en   (mem_rd_en),
      .mem_rd_addr (mem_rd_addr),
      .mem_rd_data (mem_rd_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_addr    (out_addr)
   );

   downsample_ctrl #(
      .STRIDE_Q8_8 (512),
      .HIN         (8),
      .HOUT        (5)
   ) dut_c (
      .clk         (clk),
      .rst         (rst),
      .start       (c_start),
      .abort       (1'b0),
      .busy        (c_busy),
      .done        (c_done),
      .mem_rd_en   (c_mem_rd_en),
      .mem_rd_addr (c_mem_rd_addr),
      .mem_rd_data (c_mem_rd_data),
      .out_valid   (c_out_valid),
      .out_ready   (c_out_ready),
      .out_data    (c_out_data),
      .out_addr    (c_out_addr)
   );

   // Synchronous-read SRAM models: data valid one cycle after the strobe.
   always @(posedge clk) begin
      if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
      if (c_mem_rd_en) c_mem_rd_data <= c_mem[c_mem_rd_addr];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   // Reference: source index = clamp(floor(o * stride / 256)) per axis, row-major.
   function automatic int src_of(input int hin, input int hout, input int s, input int p);
      int oy;
      int ox;
      int r;
      int c;
      oy = p / hout;
      ox = p % hout;
      r  = (oy * s) / 256;
      c  = (ox * s) / 256;
      if (r > hin - 1) r = hin - 1;
      if (c > hin - 1) c = hin - 1;
      return r * hin + c;
   endfunction

   task automatic push_map();
      for (int p = 0; p < NPIX; p++) begin
         exp_t e;
         e.addr = p;
         e.src  = src_of(HIN, HOUT, S, p);
         e.data = int'(mem[e.src]);
         exp_q.push_back(e);
      end
   endtask

   task automatic pulse_start();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic run_to_done(input int budget, output int cyc);
      cyc = 0;
      while (!done && cyc < budget) begin
         @(posedge clk); #1;
         cyc++;
      end
      check("done_reached", done, 1);
   endtask

   task automatic end_of_map_checks(input string tag);
      @(posedge clk); #1;
      check({tag, "_done_one_cycle"}, done, 0);
      check({tag, "_busy_after"}, busy, 0);
      check({tag, "_outputs"}, hs_count, NPIX);
      check({tag, "_done_count"}, done_count, 1);
      check({tag, "_queue_empty"}, exp_q.size(), 0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_rd_en"}, mem_rd_en, 0);
      check({tag, "_rd_addr"}, mem_rd_addr, 0);
      check({tag, "_valid"}, out_valid, 0);
      check({tag, "_data"}, out_data, 0);
      check({tag, "_addr"}, out_addr, 0);
   endtask

   // Monitor: pops the scoreboard on every accepted handshake of the main DUT.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (mem_rd_en) last_rd = int'(mem_rd_addr);
         if (done) done_count++;
         if (out_valid && out_ready && !abort && !rst) begin
            if (hs_count == 0) first_addr = int'(out_addr);
            hs_count++;
            obs_src[out_addr]  = last_rd;
            obs_data[out_addr] = int'(out_data);
            if (exp_q.size() == 0) begin
               n_checks++;
               $display("FAIL unexpected_output: got addr %0d expected no output", out_addr);
            end else begin
               e = exp_q.pop_front();
               check("out_addr", out_addr, e.addr);
               check("out_data", out_data, e.data);
               check("src_addr", last_rd, e.src);
            end
         end
      end
   end

   // Monitor for the clamp-configuration DUT.
   initial begin
      forever begin
         @(negedge clk);
         if (c_mem_rd_en) c_last_rd = int'(c_mem_rd_addr);
         if (c_done) c_done_count++;
         if (c_out_valid && c_out_ready && !rst && c_hs < 32) begin
            c_src[c_hs] = c_last_rd;
            c_dat[c_hs] = int'(c_out_data);
            c_adr[c_hs] = int'(c_out_addr);
            c_hs++;
         end
      end
   end

   // Consumer: always-ready or random, with a one-off 5-cycle stall on pixel 7.
   initial begin
      logic [7:0] hold_d;
      logic [8:0] hold_a;
      out_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         if (stall_armed != 0 && out_valid && out_addr == 9'd7 && !rst) begin
            stall_armed = 0;
            stall_hits++;
            hold_d = out_data;
            hold_a = out_addr;
            out_ready = 1'b0;
            for (int k = 0; k < 5; k++) begin
               @(posedge clk); #1;
               check("stall_valid", out_valid, 1);
               check("stall_data", out_data, hold_d);
               check("stall_addr", out_addr, hold_a);
               check("stall_no_rd", mem_rd_en, 0);
            end
            out_ready = 1'b1;
         end else begin
            out_ready = (ready_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
         end
      end
   end

   initial begin
      int cyc;
      int found;
      rst = 1'b1;
      start = 1'b0;
      abort = 1'b0;
      c_start = 1'b0;
      c_out_ready = 1'b1;
      for (int i = 0; i < HIN; i++)
         for (int j = 0; j < HIN; j++)
            mem[i * HIN + j] = 8'((10 * (i + j)) % 256);
      for (int a = 0; a < 64; a++) c_mem[a] = 8'(a + 100);

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("reset");
      rst = 1'b0;

      // Full map with constant ready and the pattern 10*(i+j)
      hs_count = 0; done_count = 0; first_addr = -1;
      push_map();
      pulse_start();
      run_to_done(5000, cyc);
      check("cycles_start_to_done", cyc, 3 * NPIX);
      end_of_map_checks("run1");
      check("px0_src", obs_src[0], 0);
      check("px0_data", obs_data[0], 0);
      check("px20_src", obs_src[20], 28);
      check("px20_data", obs_data[20], 20);
      check("px360_src", obs_src[360], 700);
      check("px360_data", obs_data[360], 244);
      check("colskip_ox1", obs_src[1], 1);
      check("colskip_ox2", obs_src[2], 2);
      check("colskip_ox3", obs_src[3], 4);

      // Random SRAM, random backpressure, fixed 5-cycle stall on pixel 7
      for (int a = 0; a < HIN * HIN; a++) mem[a] = 8'($urandom);
      hs_count = 0; done_count = 0;
      ready_mode = 1; stall_armed = 1; stall_hits = 0;
      push_map();
      pulse_start();
      run_to_done(20000, cyc);
      ready_mode = 0;
      end_of_map_checks("bp");
      check("stall_happened", stall_hits, 1);

      // Abort while pixel 50 is presented with out_ready high
      for (int a = 0; a < HIN * HIN; a++) mem[a] = 8'($urandom);
      hs_count = 0; done_count = 0;
      push_map();
      pulse_start();
      found = 0;
      for (int i = 0; i < 2000 && found == 0; i++) begin
         @(posedge clk); #1;
         if (out_valid && out_addr == 9'd50) found = 1;
      end
      check("abort_target_seen", found, 1);
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_valid", out_valid, 0);
      check("abort_done", done, 0);
      check("abort_rd_en", mem_rd_en, 0);
      repeat (5) @(posedge clk);
      #1;
      check("abort_handshakes", hs_count, 50);
      check("abort_no_done", done_count, 0);
      exp_q.delete();
      hs_count = 0; done_count = 0; first_addr = -1;
      push_map();
      pulse_start();
      run_to_done(5000, cyc);
      end_of_map_checks("post_abort");
      check("post_abort_first_addr", first_addr, 0);

      // Reset in CAPTURE, then restart with a start pulse while busy
      hs_count = 0; done_count = 0;
      push_map();
      pulse_start();
      found = 0;
      for (int i = 0; i < 2000 && found == 0; i++) begin
         @(posedge clk); #1;
         if (hs_count >= 30 && mem_rd_en) found = 1;
      end
      check("issue_seen", found, 1);
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      check_all_zero("midrst");
      @(posedge clk); #1;
      rst = 1'b0;
      exp_q.delete();
      hs_count = 0; done_count = 0; first_addr = -1;
      push_map();
      pulse_start();
      found = 0;
      for (int i = 0; i < 2000 && found == 0; i++) begin
         @(posedge clk); #1;
         if (out_valid && out_addr == 9'd100) found = 1;
      end
      check("stray_start_point", found, 1);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      run_to_done(5000, cyc);
      end_of_map_checks("post_rst");
      check("post_rst_first_addr", first_addr, 0);
      repeat (4) @(posedge clk);
      #1;
      check("no_restart_busy", busy, 0);

      // Clamp configuration: stride 2.0, 8x8 in, 5x5 out
      c_hs = 0; c_done_count = 0;
      @(posedge clk); #1 c_start = 1'b1;
      @(posedge clk); #1 c_start = 1'b0;
      cyc = 0;
      while (!c_done && cyc < 500) begin
         @(posedge clk); #1;
         cyc++;
      end
      check("clamp_done_reached", c_done, 1);
      @(posedge clk); #1;
      check("clamp_outputs", c_hs, 25);
      check("clamp_done_count", c_done_count, 1);
      for (int p = 0; p < 25; p++) begin
         check("clamp_src", c_src[p], src_of(8, 5, 512, p));
         check("clamp_data", c_dat[p], src_of(8, 5, 512, p) + 100);
         check("clamp_addr", c_adr[p], p);
      end
      check("clamp_row4_src_row", c_src[20] / 8, 7);
      check("clamp_row4_last_col", c_src[24], 63);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
